// File: rtl/bsg_tx_serializer.sv
// -----------------------------------------------------------------------------
// bsg_tx_serializer
//
// Captures the BSG register bank (CONTROL / DATA_0 / DATA_1) on a load strobe
// and shifts one framed word stream onto tx_line:
//   start(0) | 8 or 16 data bits | optional even parity | stop(1)
// Every bit is held for (div+1) cycles of G_CLK_TX.
//
// CONTROL layout (requires DATA_WIDTH = 8):
//   [0] enable   [1] word count (0: data0, 1: data0+data1)
//   [2] MSB-first per word   [3] parity enable   [7:4] div
//
// Ports
//   G_CLK_TX  in   transmit clock, rising edge
//   rst       in   asynchronous active-low reset
//   load      in   single-cycle frame request
//   ctrl      in   BSG_CONTROL value
//   data0     in   first data word
//   data1     in   second data word (when word count = 1)
//   tx_line   out  serial output, idles high
//   busy      out  high while a frame is in flight
//   done      out  one-cycle pulse after the stop bit
// -----------------------------------------------------------------------------
module bsg_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  G_CLK_TX,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  tx_line,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int CNT_W = IDX_W + 1;  // counts across both words

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  // Captured frame configuration
  logic                  word_cnt_q;
  logic                  msb_first_q;
  logic                  par_en_q;
  logic [3:0]            div_q;
  logic [DATA_WIDTH-1:0] data0_q;
  logic [DATA_WIDTH-1:0] data1_q;

  logic [3:0]            timer_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  parity_q;
  logic                  done_q;

  logic                  accept;
  logic                  bit_end;
  logic                  last_data;
  logic [CNT_W-1:0]      last_idx;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [IDX_W-1:0]      bit_idx;
  logic                  data_bit;

  assign accept  = load && ctrl[0] && (state == S_IDLE);
  assign bit_end = (timer_q == 4'd0);

  assign last_idx  = word_cnt_q ? CNT_W'(2*DATA_WIDTH - 1) : CNT_W'(DATA_WIDTH - 1);
  assign last_data = (bit_cnt_q == last_idx);

  // Top counter bit selects the word; MSB-first mirrors the index within it
  // (~idx == DATA_WIDTH-1-idx for a power-of-two width).
  assign cur_word = bit_cnt_q[CNT_W-1] ? data1_q : data0_q;
  assign bit_idx  = msb_first_q ? ~bit_cnt_q[IDX_W-1:0] : bit_cnt_q[IDX_W-1:0];
  assign data_bit = cur_word[bit_idx];

  assign busy = (state != S_IDLE);
  assign done = done_q;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge G_CLK_TX or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    tx_line   = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        tx_line = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_line = data_bit;
        if (bit_end && last_data) state_nxt = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_line = parity_q;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the capture registers are a handful of flops, not a memory array,
  // so they are reset with everything else to give a deterministic idle state.
  always_ff @(posedge G_CLK_TX or negedge rst) begin
    if (!rst) begin
      word_cnt_q  <= 1'b0;
      msb_first_q <= 1'b0;
      par_en_q    <= 1'b0;
      div_q       <= 4'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      timer_q     <= 4'd0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Pulse lands on the same edge that returns the FSM to IDLE.
      done_q <= (state == S_STOP) && bit_end;

      if (accept) begin
        word_cnt_q  <= ctrl[1];
        msb_first_q <= ctrl[2];
        par_en_q    <= ctrl[3];
        div_q       <= ctrl[7:4];
        data0_q     <= data0;
        data1_q     <= data1;
        timer_q     <= ctrl[7:4];
        bit_cnt_q   <= '0;
        parity_q    <= 1'b0;
      end else if (state != S_IDLE) begin
        if (bit_end) begin
          timer_q <= div_q;
          if (state == S_DATA) begin
            parity_q  <= parity_q ^ data_bit;
            bit_cnt_q <= last_data ? '0 : bit_cnt_q + 1'b1;
          end
        end else begin
          timer_q <= timer_q - 4'd1;
        end
      end
    end
  end

endmodule
